// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the N-master pipelined Wishbone arbiter.
// Optional ack watchdog is enabled by defining MEMORY_ARBITER_TIMEOUT_EN.
package memory_arbiter_pkg;

  // Arbiter top-level state: waiting for a request, or a grant is held.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } arb_state_t;

  // External Wishbone bus geometry.
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = 4;

  // Outstanding-request counter must hold 0..15.
  localparam int OUT_CNT_WIDTH = 4;

  // Ack watchdog counter width.
  localparam int WDOG_WIDTH = 8;

  // Width of an index into n ports (at least one bit).
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_rr.sv
// Combinational round-robin picker: finds the first set request bit at or
// above the pointer, wrapping at N. Produces a one-hot grant and a valid flag.
// Kept generic so it can be reused by other round-robin blocks.
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] sel;
  int               sum;

  // Scan offsets from the far end down so the nearest requester to ptr wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sel   = '0;
    idx   = '0;
    sum   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = int'(ptr) + i;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = PTR_W'(sum);
      if (req[idx]) begin
        sel   = idx;
        valid = 1'b1;
      end
    end
    if (valid) begin
      grant[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter with round-robin grant,
// per-grant outstanding-request tracking and back-pressure.
// Optional feature: MEMORY_ARBITER_TIMEOUT_EN adds an ack watchdog that
// fakes a zero-data ack and releases the grant when the slave goes silent.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]  s_wb_adr_i,
  input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]  s_wb_dat_i,
  output logic [WB_DATA_WIDTH-1:0]              s_wb_dat_o,
  input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]   s_wb_sel_i,
  input  logic [NUM_MASTERS-1:0]                s_wb_we_i,
  input  logic [NUM_MASTERS-1:0]                s_wb_stb_i,
  input  logic [NUM_MASTERS-1:0]                s_wb_cyc_i,
  output logic [NUM_MASTERS-1:0]                s_wb_ack_o,
  output logic [NUM_MASTERS-1:0]                s_wb_stall_o,
  output logic [WB_ADDR_WIDTH-1:0]              m_wb_adr_o,
  input  logic [WB_DATA_WIDTH-1:0]              m_wb_dat_i,
  output logic [WB_DATA_WIDTH-1:0]              m_wb_dat_o,
  output logic [WB_SEL_WIDTH-1:0]               m_wb_sel_o,
  output logic                                  m_wb_we_o,
  output logic                                  m_wb_stb_o,
  input  logic                                  m_wb_ack_i,
  output logic                                  m_wb_cyc_o,
  input  logic                                  m_wb_stall_i
);

  localparam int GW = index_width(NUM_MASTERS);
  localparam logic [OUT_CNT_WIDTH-1:0] OUT_MAX = OUT_CNT_WIDTH'(MAX_OUTSTANDING);

  arb_state_t               state_reg, state_next;
  logic [GW-1:0]            grant_reg, grant_next;
  logic [GW-1:0]            rr_reg, rr_next;
  logic [OUT_CNT_WIDTH-1:0] out_reg, out_next;

  logic [NUM_MASTERS-1:0]   pick_onehot;
  logic                     pick_valid;
  logic [GW-1:0]            pick_idx;
  logic [GW-1:0]            grant_succ;

  logic                     g_cyc;
  logic                     g_stb;
  logic                     out_full;
  logic                     out_nonzero;
  logic                     accept;
  logic                     ack_counted;
  logic                     timeout_hit;

  // Per-port views of the packed slave-side buses.
  logic [WB_ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
  logic [WB_DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
  logic [WB_SEL_WIDTH-1:0]  sel_arr [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_port
      assign adr_arr[gi] = s_wb_adr_i[gi*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
      assign dat_arr[gi] = s_wb_dat_i[gi*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      assign sel_arr[gi] = s_wb_sel_i[gi*WB_SEL_WIDTH +: WB_SEL_WIDTH];
    end
  endgenerate

  // Round-robin search over the raw cyc requests, starting at rr_reg.
  rr_picker #(
    .N     (NUM_MASTERS),
    .PTR_W (GW)
  ) u_picker (
    .req   (s_wb_cyc_i),
    .ptr   (rr_reg),
    .grant (pick_onehot),
    .valid (pick_valid)
  );

  // One-hot pick to port index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick_onehot[i]) begin
        pick_idx = GW'(i);
      end
    end
  end

  assign grant_succ  = (grant_reg == GW'(NUM_MASTERS - 1)) ? '0 : grant_reg + 1'b1;
  assign g_cyc       = s_wb_cyc_i[grant_reg];
  assign g_stb       = s_wb_stb_i[grant_reg];
  assign out_full    = (out_reg == OUT_MAX);
  assign out_nonzero = (out_reg != '0);
  assign accept      = m_wb_stb_o && !m_wb_stall_i;
  // Acks with nothing outstanding (including late acks after an abort) are dropped.
  assign ack_counted = (state_reg == ACTIVE) && m_wb_ack_i && out_nonzero && !timeout_hit;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  logic [WDOG_WIDTH-1:0] wdog_reg, wdog_next;

  // Fires on the TIMEOUT_CYCLES-th consecutive ack-less cycle with work outstanding.
  assign timeout_hit = (state_reg == ACTIVE) && out_nonzero && !m_wb_ack_i &&
                       (wdog_reg == WDOG_WIDTH'(TIMEOUT_CYCLES - 1));

  // Watchdog counting: cleared on ack or when the grant ends, held when idle-waiting.
  always_comb begin
    wdog_next = '0;
    if ((state_reg == ACTIVE) && (state_next == ACTIVE) && !m_wb_ack_i) begin
      wdog_next = out_nonzero ? wdog_reg + 1'b1 : wdog_reg;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_reg <= '0;
    end else begin
      wdog_reg <= wdog_next;
    end
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

  // Bus steering: the granted port drives the external bus; everyone else is stalled.
  always_comb begin
    m_wb_adr_o   = '0;
    m_wb_dat_o   = '0;
    m_wb_sel_o   = '0;
    m_wb_we_o    = 1'b0;
    m_wb_stb_o   = 1'b0;
    m_wb_cyc_o   = 1'b0;
    s_wb_ack_o   = '0;
    s_wb_stall_o = '1;
    s_wb_dat_o   = m_wb_dat_i;
    if (state_reg == ACTIVE) begin
      m_wb_adr_o              = adr_arr[grant_reg];
      m_wb_dat_o              = dat_arr[grant_reg];
      m_wb_sel_o              = sel_arr[grant_reg];
      m_wb_we_o               = s_wb_we_i[grant_reg];
      m_wb_cyc_o              = g_cyc;
      m_wb_stb_o              = g_stb && !out_full;
      s_wb_stall_o[grant_reg] = m_wb_stall_i || out_full;
      s_wb_ack_o[grant_reg]   = m_wb_ack_i && out_nonzero;
      if (timeout_hit) begin
        // Synthetic error-ack: zero data, external cycle dropped this cycle.
        m_wb_cyc_o            = 1'b0;
        m_wb_stb_o            = 1'b0;
        s_wb_ack_o[grant_reg] = 1'b1;
        s_wb_dat_o            = '0;
      end
    end
  end

  // Next-state, grant, round-robin pointer and outstanding-count update.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    rr_next    = rr_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        out_next = '0;
        if (pick_valid) begin
          state_next = ACTIVE;
          grant_next = pick_idx;
        end
      end
      ACTIVE: begin
        if (accept && !ack_counted) begin
          out_next = out_reg + 1'b1;
        end else if (!accept && ack_counted) begin
          out_next = out_reg - 1'b1;
        end
        // Release, abort and watchdog expiry all end the grant the same way.
        if (!g_cyc || timeout_hit) begin
          state_next = IDLE;
          out_next   = '0;
          rr_next    = grant_succ;
        end
      end
      default: begin
        state_next = IDLE;
        out_next   = '0;
      end
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      rr_reg    <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      rr_reg    <= rr_next;
      out_reg   <= out_next;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter (3 masters, 2 outstanding).
// A cycle-level behavioural model predicts every output each cycle; directed
// scenarios add explicit end-to-end checks. Define MEMORY_ARBITER_TIMEOUT_EN
// to include the watchdog scenario.
module tb_memory_arbiter;

  localparam int N    = 3;
  localparam int MAXO = 2;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*32-1:0] s_adr = '0;
  logic [N*32-1:0] s_dat = '0;
  logic [N*4-1:0]  s_sel = '0;
  logic [N-1:0]    s_we = '0, s_stb = '0, s_cyc = '0;
  logic [31:0]     s_dat_o;
  logic [N-1:0]    s_ack_o, s_stall_o;
  logic [31:0]     m_adr_o, m_dat_o;
  logic [31:0]     m_dat_i = '0;
  logic [3:0]      m_sel_o;
  logic            m_we_o, m_stb_o, m_cyc_o;
  logic            m_ack_i = 1'b0, m_stall_i = 1'b0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .NUM_MASTERS     (N),
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_wb_adr_i   (s_adr),
    .s_wb_dat_i   (s_dat),
    .s_wb_dat_o   (s_dat_o),
    .s_wb_sel_i   (s_sel),
    .s_wb_we_i    (s_we),
    .s_wb_stb_i   (s_stb),
    .s_wb_cyc_i   (s_cyc),
    .s_wb_ack_o   (s_ack_o),
    .s_wb_stall_o (s_stall_o),
    .m_wb_adr_o   (m_adr_o),
    .m_wb_dat_i   (m_dat_i),
    .m_wb_dat_o   (m_dat_o),
    .m_wb_sel_o   (m_sel_o),
    .m_wb_we_o    (m_we_o),
    .m_wb_stb_o   (m_stb_o),
    .m_wb_ack_i   (m_ack_i),
    .m_wb_cyc_o   (m_cyc_o),
    .m_wb_stall_i (m_stall_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // Reference model state.
  bit md_active;
  int md_grant, md_rr, md_out, md_wd;

  // Observations from the most recent cycle.
  bit          obs_acc;
  logic [N-1:0] obs_ack, obs_stall;
  logic [31:0] obs_sdat, obs_madr;
  bit          verbose = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic void model_reset();
    md_active = 1'b0;
    md_grant  = 0;
    md_rr     = 0;
    md_out    = 0;
    md_wd     = 0;
  endfunction

  function automatic bit model_timeout();
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    return md_active && (md_out > 0) && !m_ack_i && (md_wd == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: compare all outputs against the model, then advance the model.
  task automatic step();
    logic [31:0]  e_adr, e_dat, e_sdat;
    logic [3:0]   e_sel;
    logic         e_we, e_stb, e_cyc;
    logic [N-1:0] e_ack, e_stall;
    bit           to, acc, ak;
    int           g;
    @(negedge clk);
    g      = md_grant;
    to     = model_timeout();
    e_adr  = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_stb = 1'b0; e_cyc = 1'b0;
    e_ack  = '0; e_stall = '1; e_sdat = m_dat_i;
    if (md_active) begin
      e_adr      = s_adr[g*32 +: 32];
      e_dat      = s_dat[g*32 +: 32];
      e_sel      = s_sel[g*4 +: 4];
      e_we       = s_we[g];
      e_cyc      = s_cyc[g];
      e_stb      = s_stb[g] && (md_out < MAXO);
      e_stall[g] = m_stall_i || (md_out == MAXO);
      e_ack[g]   = m_ack_i && (md_out > 0);
      if (to) begin
        e_cyc    = 1'b0;
        e_stb    = 1'b0;
        e_ack[g] = 1'b1;
        e_sdat   = '0;
      end
    end
    check("m_ctl",   64'({m_cyc_o, m_stb_o, m_we_o, m_sel_o}), 64'({e_cyc, e_stb, e_we, e_sel}));
    check("m_adr",   64'(m_adr_o), 64'(e_adr));
    check("m_dat",   64'(m_dat_o), 64'(e_dat));
    check("s_ack",   64'(s_ack_o), 64'(e_ack));
    check("s_stall", 64'(s_stall_o), 64'(e_stall));
    check("s_dat",   64'(s_dat_o), 64'(e_sdat));
    obs_acc   = m_stb_o && !m_stall_i;
    obs_ack   = s_ack_o;
    obs_stall = s_stall_o;
    obs_sdat  = s_dat_o;
    obs_madr  = m_adr_o;
    if (verbose && obs_acc) begin
      $display("txn cycle=%0d port=%0d %s adr=%08h", cyc_n, g, m_we_o ? "wr" : "rd", m_adr_o);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!md_active) begin
      md_wd = 0;
      for (int i = 0; i < N; i++) begin
        if (s_cyc[(md_rr + i) % N]) begin
          md_grant  = (md_rr + i) % N;
          md_active = 1'b1;
          break;
        end
      end
    end else if (to || !s_cyc[g]) begin
      md_active = 1'b0;
      md_out    = 0;
      md_wd     = 0;
      md_rr     = (g + 1) % N;
    end else begin
      acc = e_stb && !m_stall_i;
      ak  = m_ack_i && (md_out > 0);
      if (m_ack_i) md_wd = 0;
      else if (md_out > 0) md_wd = md_wd + 1;
      md_out = md_out + int'(acc) - int'(ak);
    end
    cyc_n++;
    #1;
  endtask

  task automatic apply_reset();
    s_cyc = '0; s_stb = '0; s_we = '0;
    m_ack_i = 1'b0; m_stall_i = 1'b0;
    rst = 1'b1;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_active();
    int n = 0;
    while (!md_active && n < 20) begin
      step();
      n++;
    end
    check("grant_wait", 64'(n < 20), 64'(1));
  endtask

  logic [31:0] adr_q[$];
  int          due_q[$];
  logic [31:0] rr_exp [4];

  initial begin
    int g, n_acc, n_ack, n_stall;
    model_reset();
    rr_exp[0] = 32'h100; rr_exp[1] = 32'h200; rr_exp[2] = 32'h300; rr_exp[3] = 32'h100;

    // Reset state is compared by step() while rst is held.
    apply_reset();
    verbose = 1'b1;

    // Round robin: all cyc high, each grant does one read then drops cyc.
    s_cyc = '1;
    for (int k = 0; k < 4; k++) begin
      wait_active();
      g = md_grant;
      s_adr[g*32 +: 32] = 32'h100 * (g + 1);
      s_stb[g] = 1'b1;
      step();
      if (obs_acc) adr_q.push_back(obs_madr);
      s_stb[g] = 1'b0;
      m_ack_i = 1'b1;
      m_dat_i = 32'hD000_0000 + g;
      step();
      check("rr_ack", 64'(obs_ack[g]), 64'(1));
      m_ack_i = 1'b0;
      s_cyc[g] = 1'b0;
      step();
      s_cyc[g] = 1'b1;
    end
    check("rr_count", 64'(adr_q.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < adr_q.size()) check("rr_adr", 64'(adr_q[k]), 64'(rr_exp[k]));
    end

    // Outstanding limit: three back-to-back strobes, each ack 5 cycles after accept.
    apply_reset();
    s_cyc = 3'b001;
    wait_active();
    s_stb[0] = 1'b1;
    s_adr[31:0] = 32'h40;
    n_acc = 0; n_ack = 0; n_stall = 0;
    due_q.delete();
    for (int t = 0; t < 40 && !(n_acc == 3 && n_ack == 3); t++) begin
      m_ack_i = (due_q.size() > 0) && (due_q[0] == t);
      if (m_ack_i) void'(due_q.pop_front());
      m_dat_i = 32'hA000_0000 + t;
      step();
      if (obs_acc) begin
        n_acc++;
        due_q.push_back(t + 5);
      end
      if (obs_ack[0]) n_ack++;
      if (obs_stall[0]) n_stall++;
      if (n_acc == 3) s_stb[0] = 1'b0;
      s_adr[31:0] = s_adr[31:0] + 32'd4;
    end
    m_ack_i = 1'b0;
    check("lim_accepts", 64'(n_acc), 64'(3));
    check("lim_acks",    64'(n_ack), 64'(3));
    check("lim_stalls",  64'(n_stall), 64'(4));
    s_cyc = '0;
    step();

    // Abort: port 1 drops cyc with one outstanding; its late ack must not leak.
    apply_reset();
    s_cyc = 3'b010;
    wait_active();
    s_stb[1] = 1'b1;
    s_adr[63:32] = 32'h55;
    step();
    check("abort_accept", 64'(obs_acc), 64'(1));
    s_stb[1] = 1'b0;
    s_cyc = 3'b001;
    step();
    m_ack_i = 1'b1;
    m_dat_i = 32'hDEAD_BEEF;
    step();
    check("abort_late_ack", 64'(obs_ack), 64'(0));
    m_ack_i = 1'b0;
    s_stb[0] = 1'b1;
    s_adr[31:0] = 32'h80;
    step();
    check("abort_p0_accept", 64'(obs_acc), 64'(1));
    s_stb[0] = 1'b0;
    m_ack_i = 1'b1;
    m_dat_i = 32'hCAFE_0080;
    step();
    check("abort_p0_ack", 64'(obs_ack), 64'(3'b001));
    check("abort_p0_dat", 64'(obs_sdat), 64'(32'hCAFE_0080));
    m_ack_i = 1'b0;
    s_cyc = '0;
    step();

    // Asynchronous reset while port 1 holds two outstanding requests.
    apply_reset();
    s_cyc = 3'b010;
    wait_active();
    s_stb[1] = 1'b1;
    step();
    step();
    s_stb[1] = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_cyc",   64'(m_cyc_o), 64'(0));
    check("arst_stb",   64'(m_stb_o), 64'(0));
    check("arst_stall", 64'(s_stall_o), 64'(3'b111));
    check("arst_ack",   64'(s_ack_o), 64'(0));
    step();
    rst = 1'b0;
    step();
    m_ack_i = 1'b1;
    step();
    check("arst_cnt_zero", 64'(obs_ack), 64'(0));
    m_ack_i = 1'b0;
    s_cyc = '0;
    step();

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    // Watchdog: port 0 read never acked, port 1 waiting behind it.
    begin
      int t_hit;
      apply_reset();
      s_cyc = 3'b011;
      wait_active();
      s_stb[0] = 1'b1;
      m_dat_i = 32'h1234_5678;
      step();
      s_stb[0] = 1'b0;
      t_hit = -1;
      for (int t = 1; t <= 20 && t_hit < 0; t++) begin
        step();
        if (obs_ack[0]) begin
          t_hit = t;
          check("to_dat", 64'(obs_sdat), 64'(0));
        end
      end
      check("to_cycle", 64'(t_hit), 64'(TO));
      step();
      step();
      check("to_next_grant", 64'(obs_stall), 64'(3'b101));
      s_cyc = '0;
      step();
    end
`endif

    // Randomised traffic against the model.
    verbose = 1'b0;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 5) == 0) s_cyc[k] = ~s_cyc[k];
        s_stb[k] = 1'($urandom_range(0, 1));
        s_we[k]  = 1'($urandom_range(0, 1));
      end
      s_adr     = {$urandom(), $urandom(), $urandom()};
      s_dat     = {$urandom(), $urandom(), $urandom()};
      s_sel     = 12'($urandom());
      m_stall_i = ($urandom_range(0, 3) == 0);
      m_ack_i   = ($urandom_range(0, 2) == 0);
      m_dat_i   = $urandom();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Parametrised N-master to 1-slave pipelined Wishbone arbiter; successor to the fixed two-port (fetch/loadstore) memory block.
- Sits between the processor's bus masters (fetch, loadstore, later debug/DMA) and the external Wishbone port.
- Round-robin grant with per-grant outstanding-request tracking and back-pressure.

Parameters:
- NUM_MASTERS, 2, number of slave-side ports (master interfaces served), 2..8
- MAX_OUTSTANDING, 4, max accepted-but-unacked requests per grant, 1..15
- TIMEOUT_CYCLES, 255, ack watchdog limit (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- s_wb_adr_i  in  NUM_MASTERS*32  per-port address, port k at [32k+31:32k]
- s_wb_dat_i  in  NUM_MASTERS*32  per-port write data
- s_wb_dat_o  out  32  read data, broadcast to all ports
- s_wb_sel_i  in  NUM_MASTERS*4  per-port byte select
- s_wb_we_i  in  NUM_MASTERS  per-port write enable
- s_wb_stb_i  in  NUM_MASTERS  per-port strobe
- s_wb_cyc_i  in  NUM_MASTERS  per-port cycle (bus request)
- s_wb_ack_o  out  NUM_MASTERS  per-port ack
- s_wb_stall_o  out  NUM_MASTERS  per-port stall
- m_wb_adr_o  out  32  external address
- m_wb_dat_i  in  32  external read data
- m_wb_dat_o  out  32  external write data
- m_wb_sel_o  out  4  external byte select
- m_wb_we_o  out  1  external write enable
- m_wb_stb_o  out  1  external strobe
- m_wb_ack_i  in  1  external ack
- m_wb_cyc_o  out  1  external cycle
- m_wb_stall_i  in  1  external stall

Behaviour:
- Reset (async, rst_i=1): state IDLE, grant index 0, rr pointer 0, outstanding 0. m_wb_cyc_o/stb_o/we_o=0, adr/dat/sel=0, s_wb_ack_o=0, s_wb_stall_o=all 1.
- States: IDLE, ACTIVE.
- IDLE: requests = s_wb_cyc_i. If any set, pick first set bit searching from rr pointer upward with wrap; register grant, go ACTIVE. Grant effective the next cycle (1-cycle arbitration latency). All m_wb outputs 0; all stalls 1.
- ACTIVE: m_wb_adr/dat/sel/we driven combinationally from granted port.
  - m_wb_cyc_o = granted cyc.
  - m_wb_stb_o = granted stb and outstanding<MAX_OUTSTANDING.
  - Granted s_wb_stall_o = m_wb_stall_i or (outstanding==MAX_OUTSTANDING). Other ports: stall=1, ack=0.
  - Granted s_wb_ack_o = m_wb_ack_i and outstanding>0.
- s_wb_dat_o = m_wb_dat_i always; validity is qualified by ack only.
- Outstanding counter: +1 on accept (m_wb_stb_o and !m_wb_stall_i); -1 on counted ack. Accept and ack in the same cycle leave it unchanged. Never underflows; an ack at 0 is dropped.
- Release: granted cyc low and outstanding==0 -> IDLE. rr pointer = grant+1, wrapping at NUM_MASTERS.
- Abort: granted cyc drops with outstanding>0 -> IDLE, counter cleared. Subsequent acks are ignored until a new grant starts.
- Grant is never preempted while granted cyc is high.
- A master deasserting cyc in the same cycle it is selected in IDLE still gets ACTIVE for one cycle, then releases.

Optional Feature:
- Macro MEMORY_ARBITER_TIMEOUT_EN.
- Defined:
  - 8-bit watchdog counts ACTIVE cycles with outstanding>0 and no m_wb_ack_i; cleared on any ack or grant change.
  - On reaching TIMEOUT_CYCLES: one-cycle ack pulse to the granted port with s_wb_dat_o forced to 0; m_wb_cyc_o forced low that cycle; counter cleared; state -> IDLE with normal rr advance.
- Undefined: no watchdog logic; a missing ack holds the grant indefinitely.

Decomposition:
- Package memory_arbiter_pkg holds:
  - state enum (IDLE, ACTIVE)
  - WB_ADDR_WIDTH=32, WB_DATA_WIDTH=32, WB_SEL_WIDTH=4
  - outstanding counter width constant
- Sub-module rr_picker: combinational, NUM_MASTERS-wide request vector plus pointer in; one-hot grant and valid out. Reused later for the interrupt controller.

Test Plan:
- Reset mid-ACTIVE: port 1 granted with outstanding 2, assert rst_i asynchronously -> outputs drop immediately: m_wb_cyc_o=0, all stalls 1, counter 0.
- Round-robin, NUM_MASTERS=3, all cyc held high, each grant does one read (adr 0x100 * (k+1)) then drops cyc -> grant order 0,1,2,0. m_wb_adr_o sequence 0x100,0x200,0x300,0x100.
- Outstanding limit, MAX_OUTSTANDING=2: port 0 strobes 3 back-to-back, ack delayed 5 cycles -> 2 accepted, third stalled until first ack, then accepted. Exactly 3 acks delivered to port 0.
- Simultaneous accept and ack at outstanding=1 -> counter stays 1; stall to port 0 stays 0.
- Abort: port 1 drops cyc with 1 outstanding; slave acks one cycle later while port 0 is newly requesting -> late ack not forwarded. Port 0 granted the cycle after IDLE; its first read returns its own data.
- With MEMORY_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=8: port 0 read never acked -> at cycle 8 port 0 receives ack with dat 0. Arbiter then grants pending port 1.
